// File: rtl/debounce_scanner_if.sv
// Button bank interface: raw levels in, debounced levels and edge pulses out.
interface debounce_scanner_if #(
  parameter int unsigned N_BTN = 4
);
  logic [N_BTN-1:0] in;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] out;
  logic [N_BTN-1:0] rel;
  logic             busy;

  modport master (output in, input level, out, rel, busy);
  modport slave  (input in, output level, out, rel, busy);
endinterface

// File: rtl/debounce_scanner.sv
// Round-robin debouncer: one stability counter shared by all buttons, granted to one
// pending input at a time.
module debounce_scanner #(
  parameter int unsigned N_BTN = 4,
  parameter int unsigned N     = 10000000
) (
  input  logic              CLK50MHZ,
  input  logic              RST,
  debounce_scanner_if.slave bus
);

  localparam int unsigned IdxW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(N);

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0]  counter_q, counter_d;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] out_q, out_d;
  logic [N_BTN-1:0] rel_q, rel_d;
  logic [N_BTN-1:0] sync1_q, sync_q;

  logic [N_BTN-1:0] pending;
  logic             found;
  int unsigned      cand;
  logic [IdxW-1:0]  grant_idx, grant_nxt;

  assign pending = sync_q ^ level_q;

  // First pending bit at or after ptr, wrapping around the bank.
  always_comb begin
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      if (!found && pending[(int'(ptr_q) + k) % N_BTN]) begin
        found = 1'b1;
        cand  = (int'(ptr_q) + k) % N_BTN;
      end
    end
    grant_idx = IdxW'(cand);
    grant_nxt = IdxW'((cand + 1) % N_BTN);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    counter_d = counter_q;
    level_d   = level_q;
    out_d     = '0;
    rel_d     = '0;
    case (state_q)
      StIdle: begin
        if (found) begin
          idx_d     = grant_idx;
          ptr_d     = grant_nxt;
          counter_d = '0;
          state_d   = StCount;
        end
      end
      StCount: begin
        if (!pending[idx_q]) begin
          // Bounced back to the debounced level: drop the window silently.
          counter_d = '0;
          state_d   = StIdle;
        end else if (counter_q == CntMax) begin
          level_d[idx_q] = sync_q[idx_q];
          if (sync_q[idx_q]) begin
            out_d[idx_q] = 1'b1;
          end else begin
            rel_d[idx_q] = 1'b1;
          end
          counter_d = '0;
          state_d   = StIdle;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      ptr_q     <= '0;
      counter_q <= '0;
      level_q   <= '0;
      out_q     <= '0;
      rel_q     <= '0;
      sync1_q   <= '0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      counter_q <= counter_d;
      level_q   <= level_d;
      out_q     <= out_d;
      rel_q     <= rel_d;
      sync1_q   <= bus.in;
      sync_q    <= sync1_q;
    end
  end

  assign bus.level = level_q;
  assign bus.out   = out_q;
  assign bus.rel   = rel_q;
  assign bus.busy  = (state_q == StCount);

endmodule

// File: tb/tb_debounce_scanner.sv
// Directed bench for debounce_scanner with N_BTN=4, N=4 and hand-computed edge timing.
module tb_debounce_scanner;

  localparam int unsigned NB = 4;
  localparam int unsigned NS = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #10 clk = ~clk;

  debounce_scanner_if #(.N_BTN(NB)) bus ();

  debounce_scanner #(
    .N_BTN (NB),
    .N     (NS)
  ) dut (
    .CLK50MHZ (clk),
    .RST      (rst),
    .bus      (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Input changed just before edge 0: commit is at edge 7 when N=4.
  task automatic run_window(input int b, input logic val, input string tag);
    logic [3:0] pulse;
    for (int e = 0; e <= 8; e++) begin
      tick();
      pulse    = '0;
      pulse[b] = (e == 7);
      check_eq({tag, "_out"}, 32'(bus.out), val ? 32'(pulse) : 32'd0);
      check_eq({tag, "_rel"}, 32'(bus.rel), val ? 32'd0 : 32'(pulse));
      check_eq({tag, "_level"}, 32'(bus.level[b]), (e >= 7) ? 32'(val) : 32'(!val));
      if (e != 7) check_eq({tag, "_busy"}, 32'(bus.busy), 32'(e >= 2 && e <= 6));
    end
  endtask

  task automatic run_pair(input int first, input int second, input string tag);
    logic [3:0] pulse;
    for (int e = 0; e <= 14; e++) begin
      tick();
      pulse = '0;
      if (e == 7)  pulse[first]  = 1'b1;
      if (e == 13) pulse[second] = 1'b1;
      check_eq({tag, "_out"}, 32'(bus.out), 32'(pulse));
      check_eq({tag, "_rel"}, 32'(bus.rel), 32'd0);
    end
  endtask

  task automatic do_reset();
    bus.in = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check_eq("reset_level", 32'(bus.level), 32'd0);
    check_eq("reset_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int npulse;
    rst    = 1'b1;
    bus.in = '0;
    tick();
    tick();
    check_eq("rst_level", 32'(bus.level), 32'd0);
    check_eq("rst_out", 32'(bus.out), 32'd0);
    check_eq("rst_rel", 32'(bus.rel), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick();

    bus.in[0] = 1'b1;
    run_window(0, 1'b1, "press");
    bus.in[0] = 1'b0;
    run_window(0, 1'b0, "release");

    // Bounce: grant at edge 2, drop seen by the FSM at edge 6 -> abort.
    bus.in[2] = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      tick();
      check_eq("bounce_out", 32'(bus.out), 32'd0);
      check_eq("bounce_level", 32'(bus.level[2]), 32'd0);
      check_eq("bounce_busy", 32'(bus.busy), 32'(e >= 2 && e <= 5));
      if (e == 3) bus.in[2] = 1'b0;
    end
    bus.in[2] = 1'b1;
    run_window(2, 1'b1, "rearm");

    // Pointer now sits at 3, so bit 3 is served before bit 1.
    bus.in[1] = 1'b1;
    bus.in[3] = 1'b1;
    run_pair(3, 1, "rr_ptr3");
    check_eq("rr_ptr3_level", 32'(bus.level), 32'hE);

    do_reset();
    bus.in[1] = 1'b1;
    bus.in[3] = 1'b1;
    run_pair(1, 3, "pair");
    check_eq("pair_level", 32'(bus.level), 32'hA);

    // Bit 0 toggles every 2 cycles and keeps aborting; bit 1 commits at edge 10.
    do_reset();
    bus.in[0] = 1'b1;
    bus.in[1] = 1'b1;
    npulse = 0;
    for (int e = 0; e <= 20; e++) begin
      tick();
      check_eq("fair_out", 32'(bus.out), (e == 10) ? 32'h2 : 32'h0);
      if (bus.out[1]) npulse++;
      bus.in[0] = (((e + 1) / 2) % 2 == 0);
    end
    check_eq("fair_once", 32'(npulse), 32'd1);
    check_eq("fair_level0", 32'(bus.level[0]), 32'd0);

    // Reset with counter at 2, then a fresh full latency with the button still held.
    do_reset();
    bus.in[0] = 1'b1;
    for (int e = 0; e <= 4; e++) tick();
    check_eq("midrst_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("midrst_level", 32'(bus.level), 32'd0);
    check_eq("midrst_out", 32'(bus.out), 32'd0);
    check_eq("midrst_rel", 32'(bus.rel), 32'd0);
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    run_window(0, 1'b1, "postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
